ucsbece154b_branch_resolve: RTL and testbench
=============================================

UCSBECE154B_BRANCH_RESOLVE -- requirements
Module: ucsbece154b_branch_resolve

Interface
REQ-001 SHALL have parameter NUM_BTB_ENTRIES, default 8: BTB depth; the BTB index is pc[$clog2(NUM_BTB_ENTRIES)+1:2].
REQ-002 SHALL have parameter NUM_GHR_BITS, default 5: PHT address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports, in order:
- clk  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- pcF_i  in  32  fetch PC.
- BranchTakenF_i  in  1  predicted taken.
- BTBtargetF_i  in  32  predicted target.
- PHTreadaddressF_i  in  NUM_GHR_BITS  PHT index used at fetch.
- StallD_i  in  1  hold the D shadow register.
- FlushD_i  in  1  invalidate the D shadow register.
- FlushE_i  in  1  invalidate the E shadow register.
- opE_i  in  7  execute-stage opcode.
- TakenE_i  in  1  resolved outcome (branch condition true, or jump).
- TargetE_i  in  32  resolved target.
- MispredictE_o  out  1  redirect fetch.
- PCcorrectE_o  out  32  redirect PC.
- BTB_we_o  out  1  BTB write enable.
- BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  BTB write index.
- BTBwritedata_o  out  32  BTB write target.
- PHTwe_o  out  1  PHT/GHR update enable.
- PHTincrement_o  out  1  PHT counter direction.
- PHTwriteaddress_o  out  NUM_GHR_BITS  PHT write index.
- GHRreset_o  out  1  GHR recovery pulse.
- BranchCount_o  out  32  resolved-branch counter.
- MispredictCount_o  out  32  misprediction counter.

Function
REQ-005 SHALL carry {valid, pc, predTaken, predTarget, phtAddr} through two shadow registers, D then E; a fetch in cycle n reaches E in cycle n+2 when no stall or flush occurs.
REQ-006 D SHALL load from the F inputs with valid=1 each cycle unless StallD_i is set; StallD_i holds D.
REQ-007 FlushD_i SHALL clear D.valid and SHALL take priority over StallD_i.
REQ-008 E SHALL load from D every cycle; FlushE_i loads E.valid=0 instead.
REQ-009 E SHALL hold no stall input; the E stage never holds.
REQ-010 SHALL define isBr = (opE_i==instr_branch_op) and isJ = (opE_i==instr_jal_op or instr_jalr_op); ctl = isBr|isJ.
REQ-011 The outputs MispredictE_o, PCcorrectE_o, BTB_*, PHT_* and GHRreset_o SHALL be combinational from E.valid, the E shadow fields and the E inputs, and all SHALL be 0 when E.valid=0.
REQ-012 MispredictE_o SHALL be 1 when E.valid and any of the following holds:
- ctl and predTaken != TakenE_i.
- ctl and TakenE_i and predTarget != TargetE_i.
- !ctl and predTaken.
REQ-013 PCcorrectE_o SHALL be TargetE_i when ctl&TakenE_i, else E.pc+4 (mod 2^32, wrap-around allowed).
REQ-014 BTB_we_o SHALL be E.valid & ctl & TakenE_i & (!predTaken | predTarget != TargetE_i).
REQ-015 BTBwriteaddress_o SHALL be E.pc[$clog2(NUM_BTB_ENTRIES)+1:2], and BTBwritedata_o SHALL be TargetE_i.
REQ-016 PHTwe_o SHALL be E.valid & isBr; PHTincrement_o SHALL be TakenE_i; PHTwriteaddress_o SHALL be E.phtAddr.
REQ-017 GHRreset_o SHALL equal MispredictE_o.
REQ-018 BranchCount_o SHALL increment on each cycle with PHTwe_o=1.
REQ-019 MispredictCount_o SHALL increment on each cycle with MispredictE_o=1.
REQ-020 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-021 A FlushE_i or FlushD_i asserted in the same cycle as an E-stage mispredict SHALL NOT suppress that mispredict's outputs or counter updates.

Reset
REQ-022 On reset_ni=0, asynchronously, the D and E valid bits SHALL be 0, all shadow fields SHALL be 0, and both counters SHALL be 0; consequently every output SHALL read 0.
REQ-023 Reset mid-operation SHALL discard in-flight predictions with no BTB or PHT write.

Structure
REQ-024 Opcode constants SHALL come from ucsbece154b_defines.vh, and no new opcode constants SHALL be defined locally.
REQ-025 The shadow register SHALL be one sub-module, ucsbece154b_bp_shadow_reg (enable, clear, payload), instantiated twice.

Verification
REQ-026 Branch at pc 0x100, predicted not-taken, resolves taken to 0x80 -> MispredictE_o=1, PCcorrectE_o=0x80, BTB_we_o=1, BTBwriteaddress_o=0, PHTincrement_o=1, MispredictCount_o=1.
REQ-027 jal at pc 0x104, predTaken=1, predTarget=0x200, TargetE_i=0x200 -> MispredictE_o=0, BTB_we_o=0, PHTwe_o=0.
REQ-028 Non-control op at pc 0x108 with predTaken=1 -> MispredictE_o=1, PCcorrectE_o=0x10C, BTB_we_o=0.
REQ-029 StallD_i=1 for 2 cycles after fetch of 0x10 -> the 0x10 record stays in D, then reaches E exactly once; StallD_i=1 with FlushD_i=1 -> D.valid=0.
REQ-030 BranchCount_o preloaded to 32'hFFFFFFFF via forced state plus one resolved branch -> BranchCount_o stays 32'hFFFFFFFF.
REQ-031 reset_ni pulsed low mid-cycle while E holds a mispredicting branch -> all outputs 0 immediately, no BTB_we_o or PHTwe_o after release.

Source files
------------

// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Purpose: shared opcode constants and helpers for branch resolution.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ucsbece154b_branch_resolve_pkg;

  `include "ucsbece154b_defines.vh"

  // Statistics counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ucsbece154b_bp_shadow_reg.sv
// Purpose: one pipeline slot of branch-prediction state (payload register).
// Latency: 1 cycle from d to q when en=1.
// Backpressure: en=0 holds the contents; clr wins over en and zeroes the slot.
// Ports: clk, reset_ni (async, active-low), en (load), clr (invalidate),
//        d (next payload), q (registered payload).
module ucsbece154b_bp_shadow_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_ni,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ucsbece154b_defines.vh
// Shared RISC-V opcode constants for the ucsbece154b core.
// Included inside a package so importers see them as package localparams.
localparam logic [6:0] instr_branch_op = 7'b1100011;
localparam logic [6:0] instr_jal_op    = 7'b1101111;
localparam logic [6:0] instr_jalr_op   = 7'b1100111;

// File: rtl/ucsbece154b_branch_resolve.sv
// Purpose: carries fetch-time predictions to E and resolves them (redirect, BTB/PHT update, stats).
// Latency: fetch in cycle n is resolved combinationally in cycle n+2 when not stalled/flushed.
// Backpressure: StallD_i holds the D slot; the E slot never holds, flushes insert bubbles.
// Ports: clk, reset_ni; F-side pcF_i/BranchTakenF_i/BTBtargetF_i/PHTreadaddressF_i;
//        hazard controls StallD_i/FlushD_i/FlushE_i; E-side opE_i/TakenE_i/TargetE_i;
//        outputs: redirect (MispredictE_o, PCcorrectE_o), BTB write, PHT/GHR update,
//        and saturating BranchCount_o / MispredictCount_o.
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 8,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                               clk,
  input  logic                               reset_ni,
  input  logic [31:0]                        pcF_i,
  input  logic                               BranchTakenF_i,
  input  logic [31:0]                        BTBtargetF_i,
  input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
  input  logic                               StallD_i,
  input  logic                               FlushD_i,
  input  logic                               FlushE_i,
  input  logic [6:0]                         opE_i,
  input  logic                               TakenE_i,
  input  logic [31:0]                        TargetE_i,
  output logic                               MispredictE_o,
  output logic [31:0]                        PCcorrectE_o,
  output logic                               BTB_we_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
  output logic [31:0]                        BTBwritedata_o,
  output logic                               PHTwe_o,
  output logic                               PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
  output logic                               GHRreset_o,
  output logic [31:0]                        BranchCount_o,
  output logic [31:0]                        MispredictCount_o
);

  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic [NUM_GHR_BITS-1:0] pht_addr;
  } shadow_t;

  shadow_t d_in, d_q, e_q;
  logic    is_br, is_j, ctl, target_wrong;
  logic [31:0] branch_count_q, mispredict_count_q;

  // Every unstalled fetch is a live record; the F side has no notion of a bubble.
  always_comb begin
    d_in.valid       = 1'b1;
    d_in.pc          = pcF_i;
    d_in.pred_taken  = BranchTakenF_i;
    d_in.pred_target = BTBtargetF_i;
    d_in.pht_addr    = PHTreadaddressF_i;
  end

  ucsbece154b_bp_shadow_reg #(.W($bits(shadow_t))) u_shadow_d (
    .clk      (clk),
    .reset_ni (reset_ni),
    .en       (!StallD_i),
    .clr      (FlushD_i),
    .d        (d_in),
    .q        (d_q)
  );

  ucsbece154b_bp_shadow_reg #(.W($bits(shadow_t))) u_shadow_e (
    .clk      (clk),
    .reset_ni (reset_ni),
    .en       (1'b1),
    .clr      (FlushE_i),
    .d        (d_q),
    .q        (e_q)
  );

  assign is_br        = (opE_i == instr_branch_op);
  assign is_j         = (opE_i == instr_jal_op) || (opE_i == instr_jalr_op);
  assign ctl          = is_br | is_j;
  assign target_wrong = (e_q.pred_target != TargetE_i);

  // Everything below is gated by e_q.valid so a bubble in E can never write
  // predictor state or redirect fetch, whatever the E inputs happen to be.
  always_comb begin
    MispredictE_o     = 1'b0;
    PCcorrectE_o      = '0;
    BTB_we_o          = 1'b0;
    BTBwriteaddress_o = '0;
    BTBwritedata_o    = '0;
    PHTwe_o           = 1'b0;
    PHTincrement_o    = 1'b0;
    PHTwriteaddress_o = '0;
    if (e_q.valid) begin
      if (ctl) begin
        MispredictE_o = (e_q.pred_taken != TakenE_i) || (TakenE_i && target_wrong);
      end else begin
        // A non-control instruction that was predicted taken sent fetch astray.
        MispredictE_o = e_q.pred_taken;
      end
      PCcorrectE_o      = (ctl && TakenE_i) ? TargetE_i : e_q.pc + 32'd4;
      BTB_we_o          = ctl && TakenE_i && (!e_q.pred_taken || target_wrong);
      BTBwriteaddress_o = e_q.pc[BTB_IDX_W+1:2];
      BTBwritedata_o    = TargetE_i;
      PHTwe_o           = is_br;
      PHTincrement_o    = TakenE_i;
      PHTwriteaddress_o = e_q.pht_addr;
    end
  end

  assign GHRreset_o = MispredictE_o;

  // Counters key off the current E outputs, so a flush arriving in the same
  // cycle (which only affects the next E contents) never hides an event.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (PHTwe_o)       branch_count_q     <= sat_inc(branch_count_q);
      if (MispredictE_o) mispredict_count_q <= sat_inc(mispredict_count_q);
    end
  end

  assign BranchCount_o     = branch_count_q;
  assign MispredictCount_o = mispredict_count_q;

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Purpose: directed self-checking bench for ucsbece154b_branch_resolve.
// Latency: fetch driven in one cycle is checked two cycles later in E.
// Backpressure: exercises StallD_i/FlushD_i/FlushE_i through a small pipeline model.
module tb_ucsbece154b_branch_resolve;
  import ucsbece154b_branch_resolve_pkg::*;

  localparam logic [6:0] ALU_OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [31:0] pcF_i;
  logic        BranchTakenF_i;
  logic [31:0] BTBtargetF_i;
  logic [4:0]  PHTreadaddressF_i;
  logic        StallD_i, FlushD_i, FlushE_i;
  logic [6:0]  opE_i;
  logic        TakenE_i;
  logic [31:0] TargetE_i;
  logic        MispredictE_o;
  logic [31:0] PCcorrectE_o;
  logic        BTB_we_o;
  logic [2:0]  BTBwriteaddress_o;
  logic [31:0] BTBwritedata_o;
  logic        PHTwe_o, PHTincrement_o;
  logic [4:0]  PHTwriteaddress_o;
  logic        GHRreset_o;
  logic [31:0] BranchCount_o, MispredictCount_o;

  ucsbece154b_branch_resolve dut (
    .clk               (clk),
    .reset_ni          (reset_ni),
    .pcF_i             (pcF_i),
    .BranchTakenF_i    (BranchTakenF_i),
    .BTBtargetF_i      (BTBtargetF_i),
    .PHTreadaddressF_i (PHTreadaddressF_i),
    .StallD_i          (StallD_i),
    .FlushD_i          (FlushD_i),
    .FlushE_i          (FlushE_i),
    .opE_i             (opE_i),
    .TakenE_i          (TakenE_i),
    .TargetE_i         (TargetE_i),
    .MispredictE_o     (MispredictE_o),
    .PCcorrectE_o      (PCcorrectE_o),
    .BTB_we_o          (BTB_we_o),
    .BTBwriteaddress_o (BTBwriteaddress_o),
    .BTBwritedata_o    (BTBwritedata_o),
    .PHTwe_o           (PHTwe_o),
    .PHTincrement_o    (PHTincrement_o),
    .PHTwriteaddress_o (PHTwriteaddress_o),
    .GHRreset_o        (GHRreset_o),
    .BranchCount_o     (BranchCount_o),
    .MispredictCount_o (MispredictCount_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        misp;
    logic [31:0] pcc;
    logic        btb_we;
    logic [2:0]  btb_addr;
    logic [31:0] btb_data;
    logic        pht_we;
    logic        pht_inc;
    logic [4:0]  pht_addr;
  } exp_t;

  typedef struct {
    int          seq;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [4:0]  pha;
    logic [6:0]  op;
    logic        tk;
    logic [31:0] tgt;
    exp_t        e;
  } txn_t;

  txn_t        sb[$];
  txn_t        cur_txn;
  exp_t        cur_exp;
  logic        cur_stall, cur_fd, cur_fe;
  logic        md_v, me_v;
  int          md_seq, me_seq, seq_ctr;
  logic [31:0] br_m, mp_m;
  int          checks = 0;
  int          errors = 0;

  // Reference outcome of one record, derived from the instruction's behaviour.
  function automatic exp_t model(input txn_t t);
    exp_t r;
    logic br, ctl;
    br  = (t.op == instr_branch_op);
    ctl = br || (t.op == instr_jal_op) || (t.op == instr_jalr_op);
    r.misp     = ctl ? ((t.pt != t.tk) || (t.tk && (t.ptgt != t.tgt))) : t.pt;
    r.pcc      = (ctl && t.tk) ? t.tgt : t.pc + 32'd4;
    r.btb_we   = ctl && t.tk && (!t.pt || (t.ptgt != t.tgt));
    r.btb_addr = t.pc[4:2];
    r.btb_data = t.tgt;
    r.pht_we   = br;
    r.pht_inc  = t.tk;
    r.pht_addr = t.pha;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".misp"},     32'(MispredictE_o),     32'(cur_exp.misp));
    chk({tag, ".pccorr"},   PCcorrectE_o,           cur_exp.pcc);
    chk({tag, ".btb_we"},   32'(BTB_we_o),          32'(cur_exp.btb_we));
    chk({tag, ".btb_addr"}, 32'(BTBwriteaddress_o), 32'(cur_exp.btb_addr));
    chk({tag, ".btb_data"}, BTBwritedata_o,         cur_exp.btb_data);
    chk({tag, ".pht_we"},   32'(PHTwe_o),           32'(cur_exp.pht_we));
    chk({tag, ".pht_inc"},  32'(PHTincrement_o),    32'(cur_exp.pht_inc));
    chk({tag, ".pht_addr"}, 32'(PHTwriteaddress_o), 32'(cur_exp.pht_addr));
    chk({tag, ".ghr_rst"},  32'(GHRreset_o),        32'(cur_exp.misp));
    chk({tag, ".br_cnt"},   BranchCount_o,          br_m);
    chk({tag, ".mp_cnt"},   MispredictCount_o,      mp_m);
  endtask

  // Drive one cycle's F inputs/controls and, if the model has a record in E,
  // pop its scoreboard entry and drive the matching resolution.
  task automatic drive(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic [4:0] pha, input logic [6:0] op, input logic tk,
                       input logic [31:0] tgt, input logic stall, input logic fd,
                       input logic fe);
    cur_txn.seq  = seq_ctr;
    cur_txn.pc   = pc;
    cur_txn.pt   = pt;
    cur_txn.ptgt = ptgt;
    cur_txn.pha  = pha;
    cur_txn.op   = op;
    cur_txn.tk   = tk;
    cur_txn.tgt  = tgt;
    cur_txn.e    = model(cur_txn);
    cur_stall = stall; cur_fd = fd; cur_fe = fe;
    pcF_i = pc; BranchTakenF_i = pt; BTBtargetF_i = ptgt; PHTreadaddressF_i = pha;
    StallD_i = stall; FlushD_i = fd; FlushE_i = fe;
    if (me_v) begin
      while (sb.size() > 0 && sb[0].seq < me_seq) void'(sb.pop_front());
    end
    if (me_v && sb.size() > 0 && sb[0].seq == me_seq) begin
      opE_i = sb[0].op; TakenE_i = sb[0].tk; TargetE_i = sb[0].tgt;
      cur_exp = sb[0].e;
      void'(sb.pop_front());
    end else begin
      if (me_v) chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
      // Bubble in E: present a taken branch so any missing valid-gating shows up.
      opE_i = instr_branch_op; TakenE_i = 1'b1; TargetE_i = 32'hDEAD_BEE0;
      cur_exp = '0;
    end
  endtask

  task automatic advance();
    logic ne_v;
    int   ne_seq;
    @(posedge clk);
    if (cur_exp.pht_we) br_m = sat_inc(br_m);
    if (cur_exp.misp)   mp_m = sat_inc(mp_m);
    ne_v   = cur_fe ? 1'b0 : md_v;
    ne_seq = md_seq;
    if (cur_fd) begin
      md_v = 1'b0;
    end else if (!cur_stall) begin
      md_v = 1'b1; md_seq = cur_txn.seq;
      sb.push_back(cur_txn);
      seq_ctr++;
    end
    me_v = ne_v; me_seq = ne_seq;
    #1;
  endtask

  task automatic cyc(input string tag, input logic [31:0] pc, input logic pt,
                     input logic [31:0] ptgt, input logic [4:0] pha, input logic [6:0] op,
                     input logic tk, input logic [31:0] tgt, input logic stall,
                     input logic fd, input logic fe);
    drive(pc, pt, ptgt, pha, op, tk, tgt, stall, fd, fe);
    @(negedge clk);
    check_all(tag);
    advance();
  endtask

  task automatic idle(input string tag, input logic [31:0] pc);
    cyc(tag, pc, 1'b0, 32'h0, 5'h00, ALU_OP, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    md_v = 1'b0; me_v = 1'b0; md_seq = -1; me_seq = -1; seq_ctr = 0;
    br_m = '0; mp_m = '0; cur_exp = '0;
    reset_ni = 1'b0;
    pcF_i = '0; BranchTakenF_i = 1'b0; BTBtargetF_i = '0; PHTreadaddressF_i = '0;
    StallD_i = 1'b0; FlushD_i = 1'b0; FlushE_i = 1'b0;
    opE_i = instr_branch_op; TakenE_i = 1'b1; TargetE_i = 32'h1234_5678;
    @(posedge clk); #1;
    check_all("reset");
    reset_ni = 1'b1;

    // Resolution patterns; each record is checked two cycles after its fetch.
    cyc("c1",  32'h100, 1'b0, 32'h0,   5'h03, instr_branch_op, 1'b1, 32'h80,  1'b0, 1'b0, 1'b0);
    cyc("c2",  32'h104, 1'b1, 32'h200, 5'h04, instr_jal_op,    1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc("c3",  32'h108, 1'b1, 32'h300, 5'h00, ALU_OP,          1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    cyc("c4",  32'h10C, 1'b1, 32'h400, 5'h07, instr_jalr_op,   1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    cyc("c5",  32'h110, 1'b1, 32'h50,  5'h1F, instr_branch_op, 1'b0, 32'h50,  1'b0, 1'b0, 1'b0);
    cyc("c6",  32'h114, 1'b1, 32'h60,  5'h11, instr_branch_op, 1'b1, 32'h60,  1'b0, 1'b0, 1'b0);
    cyc("c7",  32'hFFFF_FFFC, 1'b0, 32'h0, 5'h02, ALU_OP,      1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    // 0x10 sits in D across a two-cycle stall (E takes bubbles), then moves on once.
    idle("c8", 32'h10);
    cyc("c9",  32'h20, 1'b1, 32'h999, 5'h01, ALU_OP, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc("c10", 32'h24, 1'b1, 32'h999, 5'h01, ALU_OP, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle("c11", 32'h28);
    idle("c12", 32'h2C);
    // Stall together with FlushD must still invalidate D.
    cyc("c13", 32'h30, 1'b1, 32'h999, 5'h01, ALU_OP, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle("c14", 32'h34);
    idle("c15", 32'h38);
    // FlushD/FlushE in the same cycle as an E-stage mispredict must not hide it.
    cyc("c16", 32'h40, 1'b0, 32'h0, 5'h09, instr_branch_op, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    idle("c17", 32'h44);
    cyc("c18", 32'h48, 1'b0, 32'h0, 5'h00, ALU_OP, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle("c19", 32'h4C);

    // Branch counter saturation: preload all-ones just before a branch resolves.
    cyc("s1", 32'h200, 1'b0, 32'h0, 5'h05, instr_branch_op, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle("s2", 32'h204);
    force dut.branch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    br_m = 32'hFFFF_FFFF;
    idle("s3", 32'h208);
    idle("s4", 32'h20C);

    // Asynchronous reset while E holds a mispredicting branch.
    cyc("r1", 32'h300, 1'b0, 32'h0, 5'h0A, instr_branch_op, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    idle("r2", 32'h304);
    drive(32'h308, 1'b0, 32'h0, 5'h00, ALU_OP, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("r3.pre_misp", 32'(MispredictE_o), 32'd1);
    #1;
    reset_ni = 1'b0;
    #1;
    md_v = 1'b0; me_v = 1'b0; br_m = '0; mp_m = '0; cur_exp = '0;
    sb.delete();
    check_all("r3.async");
    @(negedge clk);
    reset_ni = 1'b1;
    advance();
    idle("r4", 32'h30C);
    idle("r5", 32'h310);
    idle("r6", 32'h314);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
